// File: rtl/point_gen_stream.sv
// point_gen_stream: emits NUM_POINTS 3-D points per run, either linear steps
// or a raster walk over an origin-anchored box, through a valid/ready stream.
// Optional feature macro: POINT_GEN_SAT_EN (linear add saturates, drives ovf).
// Without the macro the linear add wraps mod 2^N and ovf stays 0.
module point_gen_stream #(
  parameter int N          = 3,
  parameter int NUM_POINTS = 14,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [N-1:0]     X0,
  input  logic [N-1:0]     Y0,
  input  logic [N-1:0]     Z0,
  input  logic [N-1:0]     DX,
  input  logic [N-1:0]     DY,
  input  logic [N-1:0]     DZ,
  input  logic             out_ready,
  output logic [N-1:0]     X1,
  output logic [N-1:0]     Y1,
  output logic [N-1:0]     Z1,
  output logic             out_valid,
  output logic             out_last,
  output logic [IDX_W-1:0] idx,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);

  state_t           r_state;
  logic             r_mode;
  logic [N-1:0]     r_x0, r_y0, r_z0;
  logic [N-1:0]     r_dx, r_dy, r_dz;
  logic [N-1:0]     r_x, r_y, r_z;
  logic [IDX_W-1:0] r_idx;
  logic             r_valid, r_last, r_busy, r_done, r_ovf;

  // One linear step on one axis; MSB of the result flags a clamp.
  function automatic logic [N:0] lin_step(input logic [N-1:0] p, input logic [N-1:0] d);
`ifdef POINT_GEN_SAT_EN
    logic [N+1:0] sum;
    // Unsigned point plus signed step, evaluated wide enough to see both overflow directions.
    sum = {2'b00, p} + {{2{d[N-1]}}, d};
    if (sum[N+1])
      lin_step = {1'b1, {N{1'b0}}};
    else if (sum[N])
      lin_step = {1'b1, {N{1'b1}}};
    else
      lin_step = {1'b0, sum[N-1:0]};
`else
    lin_step = {1'b0, p + d};
`endif
  endfunction

  logic [N:0]   w_lx, w_ly, w_lz;
  logic [N-1:0] w_xe, w_ye, w_ze;
  logic         w_x_wrap, w_y_wrap, w_z_wrap;
  logic [N-1:0] w_rx, w_ry, w_rz;
  logic [N-1:0] w_nx, w_ny, w_nz;
  logic         w_clamp;

  // Candidate next point for both modes, selected by the latched mode.
  always_comb begin
    w_lx = lin_step(r_x, r_dx);
    w_ly = lin_step(r_y, r_dy);
    w_lz = lin_step(r_z, r_dz);

    // Raster end points compare mod 2^N, so an extent may wrap past 2^N-1.
    w_xe = r_x0 + r_dx;
    w_ye = r_y0 + r_dy;
    w_ze = r_z0 + r_dz;
    w_x_wrap = (r_x == w_xe);
    w_y_wrap = (r_y == w_ye);
    w_z_wrap = (r_z == w_ze);

    w_rx = w_x_wrap ? r_x0 : r_x + N'(1);
    w_ry = r_y;
    w_rz = r_z;
    if (w_x_wrap) begin
      w_ry = w_y_wrap ? r_y0 : r_y + N'(1);
      if (w_y_wrap)
        w_rz = w_z_wrap ? r_z0 : r_z + N'(1);
    end

    if (r_mode) begin
      w_nx    = w_rx;
      w_ny    = w_ry;
      w_nz    = w_rz;
      w_clamp = 1'b0;
    end else begin
      w_nx    = w_lx[N-1:0];
      w_ny    = w_ly[N-1:0];
      w_nz    = w_lz[N-1:0];
      w_clamp = w_lx[N] | w_ly[N] | w_lz[N];
    end
  end

  // Control FSM: latch a run on start, advance on each accepted point.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_x0    <= '0;
      r_y0    <= '0;
      r_z0    <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_dz    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode  <= mode;
            r_x0    <= X0;
            r_y0    <= Y0;
            r_z0    <= Z0;
            r_dx    <= DX;
            r_dy    <= DY;
            r_dz    <= DZ;
            r_x     <= X0;
            r_y     <= Y0;
            r_z     <= Z0;
            r_idx   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_last  <= (LAST_IDX == '0);
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (out_ready) begin
            if (r_last) begin
              // Final point accepted: point registers keep their value, stream closes.
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_x    <= w_nx;
              r_y    <= w_ny;
              r_z    <= w_nz;
              r_idx  <= r_idx + IDX_W'(1);
              r_last <= ((r_idx + IDX_W'(1)) == LAST_IDX);
              r_ovf  <= r_ovf | w_clamp;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign X1        = r_x;
  assign Y1        = r_y;
  assign Z1        = r_z;
  assign idx       = r_idx;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_point_gen_stream.sv
// Testbench for point_gen_stream: table-driven runs with hand-computed point
// sequences, plus sequences for backpressure, mid-run reset, ignored start
// and start in the done cycle. Expectations follow POINT_GEN_SAT_EN if defined.
`timescale 1ns/1ps
module tb_point_gen_stream;
  localparam int N  = 3;
  localparam int NP = 14;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start, mode, out_ready;
  logic [N-1:0]  X0, Y0, Z0, DX, DY, DZ;
  logic [N-1:0]  X1, Y1, Z1;
  logic          out_valid, out_last, busy, done, ovf;
  logic [IW-1:0] idx;

  point_gen_stream #(.N(N), .NUM_POINTS(NP), .IDX_W(IW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .X0(X0), .Y0(Y0), .Z0(Z0), .DX(DX), .DY(DY), .DZ(DZ),
    .out_ready(out_ready),
    .X1(X1), .Y1(Y1), .Z1(Z1),
    .out_valid(out_valid), .out_last(out_last), .idx(idx),
    .busy(busy), .done(done), .ovf(ovf)
  );

  typedef struct {
    logic         mode;
    logic [N-1:0] x0, y0, z0, dx, dy, dz;
    int           ovf_from;
  } vec_t;

  vec_t vecs[4];
  int   exp_x[4][NP];
  int   exp_y[4][NP];
  int   exp_z[4][NP];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic set_vec(input int i, input logic m, input int x0, input int y0, input int z0,
                         input int dx, input int dy, input int dz, input int of);
    vecs[i].mode = m;
    vecs[i].x0 = N'(x0); vecs[i].y0 = N'(y0); vecs[i].z0 = N'(z0);
    vecs[i].dx = N'(dx); vecs[i].dy = N'(dy); vecs[i].dz = N'(dz);
    vecs[i].ovf_from = of;
  endtask

  task automatic launch(input int v);
    mode = vecs[v].mode;
    X0 = vecs[v].x0; Y0 = vecs[v].y0; Z0 = vecs[v].z0;
    DX = vecs[v].dx; DY = vecs[v].dy; DZ = vecs[v].dz;
    start = 1'b1;
  endtask

  // Start must already be driven; runs the stream and checks every visible point.
  task automatic run_vec(input int v, input int stall_at, input int stall_len,
                         input int poke_at, input int chain);
    int k, guard, stalled, xfers;
    bit poked;
    k = 0; guard = 0; stalled = 0; xfers = 0; poked = 0;
    @(posedge clk); #1;
    while (k < NP && guard < 100) begin
      guard++;
      start = 1'b0;
      if (out_valid !== 1'b1) begin
        chk("out_valid", 32'(out_valid), 32'd1);
        break;
      end
      chk("x", 32'(X1), 32'(exp_x[v][k]));
      chk("y", 32'(Y1), 32'(exp_y[v][k]));
      chk("z", 32'(Z1), 32'(exp_z[v][k]));
      chk("idx", 32'(idx), 32'(k));
      chk("out_last", 32'(out_last), 32'(k == NP-1));
      chk("busy", 32'(busy), 32'd1);
      chk("ovf", 32'(ovf), 32'(k >= vecs[v].ovf_from));
      if (k == poke_at && !poked) begin
        poked = 1;
        start = 1'b1;
        mode = ~mode;
        X0 = ~X0; Y0 = ~Y0; Z0 = ~Z0; DX = DX + 3'd1;
      end
      if (k == stall_at && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
        $display("xfer run=%0d idx=%0d point=(%0d,%0d,%0d)", v, k, X1, Y1, Z1);
        xfers++;
        k++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (guard >= 100) chk("run_timeout", 32'd0, 32'd1);
    chk("xfer_count", 32'(xfers), 32'(NP));
    chk("done", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("valid_in_done", 32'(out_valid), 32'd0);
    chk("last_in_done", 32'(out_last), 32'd0);
    if (chain >= 0) begin
      launch(chain);
    end else begin
      @(posedge clk); #1;
      chk("done_width", 32'(done), 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x"}, 32'(X1), 32'd0);
    chk({tag, "_y"}, 32'(Y1), 32'd0);
    chk({tag, "_z"}, 32'(Z1), 32'd0);
    chk({tag, "_idx"}, 32'(idx), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    // Vector 0: linear wrap, origin (6,1,1), D = (+1, 0, -1)
    // Vector 1: raster, origin (0,0,0), D = (1,1,0)
    // Vector 2: raster with wrapping X extent and zero Y extent
    // Vector 3: linear, origin (0,7,3), D = (-1, -1, +2)
`ifdef POINT_GEN_SAT_EN
    set_vec(0, 1'b0, 6, 1, 1, 1, 0, 7, 2);
    set_vec(3, 1'b0, 0, 7, 3, 7, 7, 2, 1);
    exp_x[0] = '{6,7,7,7,7,7,7,7,7,7,7,7,7,7};
    exp_z[0] = '{1,0,0,0,0,0,0,0,0,0,0,0,0,0};
    exp_x[3] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    exp_y[3] = '{7,6,5,4,3,2,1,0,0,0,0,0,0,0};
    exp_z[3] = '{3,5,7,7,7,7,7,7,7,7,7,7,7,7};
`else
    set_vec(0, 1'b0, 6, 1, 1, 1, 0, 7, 99);
    set_vec(3, 1'b0, 0, 7, 3, 7, 7, 2, 99);
    exp_x[0] = '{6,7,0,1,2,3,4,5,6,7,0,1,2,3};
    exp_z[0] = '{1,0,7,6,5,4,3,2,1,0,7,6,5,4};
    exp_x[3] = '{0,7,6,5,4,3,2,1,0,7,6,5,4,3};
    exp_y[3] = '{7,6,5,4,3,2,1,0,7,6,5,4,3,2};
    exp_z[3] = '{3,5,7,1,3,5,7,1,3,5,7,1,3,5};
`endif
    exp_y[0] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1};
    set_vec(1, 1'b1, 0, 0, 0, 1, 1, 0, 99);
    exp_x[1] = '{0,1,0,1,0,1,0,1,0,1,0,1,0,1};
    exp_y[1] = '{0,0,1,1,0,0,1,1,0,0,1,1,0,0};
    exp_z[1] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    set_vec(2, 1'b1, 6, 0, 2, 2, 0, 1, 99);
    exp_x[2] = '{6,7,0,6,7,0,6,7,0,6,7,0,6,7};
    exp_y[2] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    exp_z[2] = '{2,2,2,3,3,3,2,2,2,3,3,3,2,2};

    reset_n = 1'b0; start = 1'b0; mode = 1'b0; out_ready = 1'b1;
    X0 = '0; Y0 = '0; Z0 = '0; DX = '0; DY = '0; DZ = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Table-driven runs
    for (int v = 0; v < 4; v++) begin
      launch(v);
      run_vec(v, -1, 0, -1, -1);
    end

    // Backpressure: three stall cycles at idx 2
    launch(2);
    run_vec(2, 2, 3, -1, -1);

    // start at idx 3 with a different origin is ignored
    launch(0);
    run_vec(0, -1, 0, 3, -1);

    // Reset in the middle of a run
    launch(1);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 20 && idx != 4'd5; c++) begin
      @(posedge clk); #1;
    end
    chk("reached_idx5", 32'(idx), 32'd5);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk_all_zero("midrun_reset");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("no_done_after_reset", 32'(done), 32'd0);
      chk("idle_after_reset", 32'(out_valid), 32'd0);
    end

    // Restart from origin, then a start in the done cycle chains the next run
    launch(0);
    run_vec(0, -1, 0, -1, 2);
    run_vec(2, -1, 0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/point_gen_stream.md
# point_gen_stream

Parametrised successor to `point_gen`. It emits a bounded sequence of `NUM_POINTS` 3-D integer points (X, Y, Z) from a latched origin and a per-run step/extent, in either linear-step or raster-walk mode. Points leave through a valid/ready stream so downstream coordinate-transform or plotting stages can stall the generator. The block sits between the control register front end and the coordinate pipeline.

## Interface

- `N`, 3, coordinate width in bits (unsigned coordinates; steps are two's complement)
- `NUM_POINTS`, 14, points emitted per run, 1..2^`IDX_W`
- `IDX_W`, 4, width of the point index output
- `clk`  input  1  rising-edge clock
- `reset_n`  input  1  synchronous, active-low reset
- `start`  input  1  one-cycle request to begin a run; ignored while `busy`
- `mode`  input  1  0 = linear step, 1 = raster walk; latched on accepted `start`
- `X0`, `Y0`, `Z0`  input  N each  origin; latched on accepted `start`
- `DX`, `DY`, `DZ`  input  N each  linear: signed step per point; raster: unsigned extent (axis spans origin..origin+D); latched on accepted `start`
- `out_ready`  input  1  downstream accepts the current point
- `X1`, `Y1`, `Z1`  output  N each  current point
- `out_valid`  output  1  current point valid
- `out_last`  output  1  current point is the final one of the run
- `idx`  output  IDX_W  index of current point, 0-based
- `busy`  output  1  run in progress
- `done`  output  1  one-cycle pulse after the final point is accepted
- `ovf`  output  1  sticky saturation flag (meaningful only with `POINT_GEN_SAT_EN`)

## Operation

- States: IDLE, RUN.
- IDLE: `busy`=0, `out_valid`=0. `start`=1 latches `mode`, origin, and D*; loads point 0 = origin; clears `idx` and `ovf`; moves to RUN.
- RUN: `out_valid`=1, `busy`=1. A transfer occurs on `out_valid && out_ready`. After each non-final transfer, the block computes the next point and increments `idx`.
- The final transfer (`idx == NUM_POINTS-1`) moves the block to IDLE and pulses `done` in the following cycle.
- `out_last` = RUN && `idx == NUM_POINTS-1`.
- Linear mode: X1 += sign-extended DX each point, likewise Y and Z. The add is mod 2^N (wrap).
- Raster mode: X steps +1. When X reaches X0+DX (mod 2^N compare), X returns to X0 and Y steps +1. When Y also reaches Y0+DY, Y returns to Y0 and Z steps +1. When Z also reaches Z0+DZ, Z returns to Z0 and the volume restarts. Termination depends only on `NUM_POINTS`.
- Raster with D*=0 on an axis: that axis is constant and carries immediately into the next axis.
- `start` while `busy` is ignored; latched values do not change.
- `reset_n`=0 at any point, including mid-run: the next edge forces IDLE. All outputs go to 0 (`X1`/`Y1`/`Z1`/`idx`/`out_valid`/`out_last`/`busy`/`done`/`ovf`).

## Timing

- `start` sampled at edge t → `out_valid`=1 with point 0 from edge t+1 (latency 1).
- With `out_ready` held high, the block emits one point per cycle, i.e. `NUM_POINTS` points in `NUM_POINTS` consecutive cycles.
- When `out_valid && !out_ready`, `X1`/`Y1`/`Z1`/`idx`/`out_last` must be held stable.
- `done` is high exactly one cycle, at edge t+1 after the final transfer at edge t. `busy` is already 0 in that cycle.
- A new `start` is accepted in the same cycle `done` is high. Back-to-back runs therefore have one idle cycle between them.
- All outputs are registered; no combinational path from `out_ready` to the data outputs. `out_ready` to state is permitted.

## Configuration

- `POINT_GEN_SAT_EN` defined: the linear-mode add saturates per axis at 0 and 2^N-1, and any clamp sets sticky `ovf` until the next accepted `start` or reset. Raster mode is unaffected.
- `POINT_GEN_SAT_EN` undefined: the linear add wraps mod 2^N and `ovf` is tied to 0.

## Test plan

- Linear wrap, N=3, origin (6,1,1), D=(1,0,7), `out_ready`=1: X = 6,7,0,1,…; Y = 1 constant; Z = 1,0,7,6,…. Exactly 14 valids; `out_last` on `idx`=13; `done` on the next cycle.
- Saturation with `POINT_GEN_SAT_EN`, origin (6,1,1), D=(1,0,7): X = 6,7,7,7,…; Z = 1,0,0,…; `ovf`=1 from the third point onward. Without the macro, `ovf` stays 0.
- Raster, origin (0,0,0), D=(1,1,0), NUM_POINTS=6: (0,0,0),(1,0,0),(0,1,0),(1,1,0),(0,0,0),(1,0,0).
- Backpressure: deassert `out_ready` for 3 cycles at `idx`=2. Point and `idx` hold for 3 cycles, the sequence then resumes unchanged, and the total transfer count is still 14.
- Reset mid-run: `reset_n`=0 for one cycle at `idx`=5 → all outputs 0 on the next edge; no `done`. A following `start` restarts from the origin with `idx`=0.
- `start` pulsed at `idx`=3 with a different origin: ignored; the run completes with the original values. `start` in the `done` cycle is accepted.
